// File: rtl/perceptron_trainer.sv
// perceptron_trainer: sequences one perceptron training step (load, settle, eval, weight write).
// Define TRAINER_SATURATE_EN to make weight updates saturate; otherwise they wrap.
module perceptron_trainer #(
  parameter int fp_integer_width = 4,
  parameter int fp_fract_width = 12,
  parameter int settle_cycles = 2,
  localparam int fp_width = fp_integer_width + fp_fract_width
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [fp_width-1:0] in1,
  input  logic [fp_width-1:0] in2,
  input  logic                target,
  input  logic [3:0]          rate,
  input  logic [fp_width-1:0] weight1,
  input  logic [fp_width-1:0] weight2,
  input  logic                result,
  input  logic                clear,
  output logic [fp_width-1:0] in1_out,
  output logic [fp_width-1:0] in2_out,
  output logic                input_ld,
  output logic [fp_width-1:0] weight1_new,
  output logic [fp_width-1:0] weight2_new,
  output logic                weight_ld,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [15:0]         err_count
);
  typedef enum logic [2:0] {IDLE, LOAD, SETTLE, EVAL, WRITE, DONE} state_t;
  state_t state_q, state_d;
  logic [fp_width-1:0] in1_q, in1_d, in2_q, in2_d, w1_q, w1_d, w2_q, w2_d;
  logic [3:0] rate_q, rate_d, cnt_q, cnt_d;
  logic tgt_q, tgt_d, err_q, err_d;
  logic [15:0] ec_q, ec_d;

  function automatic logic [fp_width-1:0] upd(input logic [fp_width-1:0] w, x,
                                              input logic [3:0] r, input logic t);
`ifdef TRAINER_SATURATE_EN
    // one guard bit so the negated shift and the sum never lose their sign
    logic signed [fp_width:0] sh, sum;
    sh = $signed({x[fp_width-1], x}) >>> r;
    sum = $signed({w[fp_width-1], w}) + (t ? sh : -sh);
    return (sum[fp_width] != sum[fp_width-1])
      ? (sum[fp_width] ? {1'b1, {(fp_width-1){1'b0}}} : {1'b0, {(fp_width-1){1'b1}}})
      : sum[fp_width-1:0];
`else
    logic signed [fp_width-1:0] sh;
    sh = $signed(x) >>> r;
    return w + (t ? sh : -sh);
`endif
  endfunction

  always_comb begin
    state_d = state_q;
    in1_d = in1_q;
    in2_d = in2_q;
    rate_d = rate_q;
    tgt_d = tgt_q;
    cnt_d = cnt_q;
    err_d = err_q;
    w1_d = w1_q;
    w2_d = w2_q;
    ec_d = ec_q;
    case (state_q)
      IDLE: if (start) begin
        in1_d = in1;
        in2_d = in2;
        rate_d = rate;
        tgt_d = target;
        state_d = LOAD;
      end
      LOAD: state_d = SETTLE;
      SETTLE: begin
        cnt_d = (cnt_q == 4'(settle_cycles - 1)) ? 4'd0 : cnt_q + 4'd1;
        state_d = (cnt_q == 4'(settle_cycles - 1)) ? EVAL : SETTLE;
      end
      EVAL: begin
        err_d = result != tgt_q;
        w1_d = err_d ? upd(weight1, in1_q, rate_q, tgt_q) : weight1;
        w2_d = err_d ? upd(weight2, in2_q, rate_q, tgt_q) : weight2;
        ec_d = (err_d && ec_q != 16'hFFFF) ? ec_q + 16'd1 : ec_q;
        state_d = WRITE;
      end
      WRITE: state_d = DONE;
      default: state_d = IDLE;
    endcase
    if (clear) ec_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      in1_q <= '0;
      in2_q <= '0;
      rate_q <= '0;
      tgt_q <= 1'b0;
      cnt_q <= '0;
      err_q <= 1'b0;
      w1_q <= '0;
      w2_q <= '0;
      ec_q <= '0;
    end else begin
      state_q <= state_d;
      in1_q <= in1_d;
      in2_q <= in2_d;
      rate_q <= rate_d;
      tgt_q <= tgt_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
      w1_q <= w1_d;
      w2_q <= w2_d;
      ec_q <= ec_d;
    end
  end

  assign in1_out = in1_q;
  assign in2_out = in2_q;
  assign input_ld = state_q == LOAD;
  assign weight_ld = state_q == WRITE && err_q;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign error = err_q;
  assign err_count = ec_q;
  assign weight1_new = w1_q;
  assign weight2_new = w2_q;
endmodule

// File: tb/tb_perceptron_trainer.sv
// tb_perceptron_trainer: directed checks of perceptron_trainer with default parameters.
module tb_perceptron_trainer;
  logic clk = 0, rst_n = 0, start = 0, target = 0, result = 0, clear = 0;
  logic [3:0] rate = 0;
  logic [15:0] in1 = 0, in2 = 0, weight1 = 0, weight2 = 0;
  logic [15:0] in1_out, in2_out, weight1_new, weight2_new, err_count;
  logic input_ld, weight_ld, busy, done, error;
  int tests = 0, fails = 0;
  int ild_n, ild_cyc, wld_cyc, done_cyc, done_n, wl, dn;
  logic [15:0] o1, o2;
  logic err_at_done;

  perceptron_trainer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in1(in1), .in2(in2), .target(target),
    .rate(rate), .weight1(weight1), .weight2(weight2), .result(result), .clear(clear),
    .in1_out(in1_out), .in2_out(in2_out), .input_ld(input_ld), .weight1_new(weight1_new),
    .weight2_new(weight2_new), .weight_ld(weight_ld), .busy(busy), .done(done),
    .error(error), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic setup(input logic [15:0] a, b, w1, w2, input logic [3:0] r, input logic t, res);
    @(negedge clk);
    in1 = a; in2 = b; weight1 = w1; weight2 = w2; rate = r; target = t; result = res;
  endtask

  // start at cycle 0, observe cycles 1..10; the sample inputs are scrambled once accepted
  task automatic run_step(input int pulse_at, input int clear_at);
    @(negedge clk);
    start = 1;
    @(posedge clk); #1;
    start = 0;
    in1 = 16'h7777; in2 = 16'h1111; rate = 4'd0; target = ~target;
    ild_n = 0; ild_cyc = -1; wld_cyc = -1; done_cyc = -1; done_n = 0; err_at_done = 1'bx;
    for (int k = 1; k <= 10; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      if (input_ld) begin ild_n++; ild_cyc = k; o1 = in1_out; o2 = in2_out; end
      if (weight_ld) wld_cyc = k;
      if (done) begin done_n++; done_cyc = k; err_at_done = error; end
      start = (k == pulse_at);
      clear = (k == clear_at);
    end
    start = 0;
    clear = 0;
  endtask

  initial begin
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_input_ld", input_ld, 0);
    chk("rst_weight_ld", weight_ld, 0);
    chk("rst_error", error, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_w1", weight1_new, 0);
    chk("rst_in1_out", in1_out, 0);
    @(negedge clk) rst_n = 1;

    setup(16'h1000, 16'hF000, 16'h0800, 16'h0000, 4'd1, 1, 0);
    run_step(0, 0);
    chk("corr_ild_n", ild_n, 1);
    chk("corr_ild_cyc", ild_cyc, 1);
    chk("corr_in1_out", o1, 16'h1000);
    chk("corr_in2_out", o2, 16'hF000);
    chk("corr_wld_cyc", wld_cyc, 5);
    chk("corr_done_cyc", done_cyc, 6);
    chk("corr_done_n", done_n, 1);
    chk("corr_error", err_at_done, 1);
    chk("corr_w1", weight1_new, 16'h1000);
    chk("corr_w2", weight2_new, 16'hF800);
    chk("corr_err_count", err_count, 1);

    setup(16'h1000, 16'h1000, 16'h1234, 16'h0042, 4'd1, 1, 1);
    run_step(0, 0);
    chk("ok_wld", wld_cyc, -1);
    chk("ok_done_cyc", done_cyc, 6);
    chk("ok_error", err_at_done, 0);
    chk("ok_w1", weight1_new, 16'h1234);
    chk("ok_w2", weight2_new, 16'h0042);
    chk("ok_err_count", err_count, 1);
    weight1 = 16'hAAAA;
    repeat (3) @(posedge clk);
    #1 chk("hold_w1", weight1_new, 16'h1234);

    setup(16'h0400, 16'hF000, 16'h1000, 16'h0000, 4'd2, 0, 1);
    run_step(0, 0);
    chk("neg_wld_cyc", wld_cyc, 5);
    chk("neg_w1", weight1_new, 16'h0F00);
    chk("neg_w2", weight2_new, 16'h0400);
    chk("neg_err_count", err_count, 2);

    setup(16'h1000, 16'h0000, 16'h7F00, 16'h0000, 4'd0, 1, 0);
    run_step(0, 0);
`ifdef TRAINER_SATURATE_EN
    chk("ovf_w1", weight1_new, 16'h7FFF);
`else
    chk("ovf_w1", weight1_new, 16'h8F00);
`endif
    chk("ovf_w2", weight2_new, 16'h0000);
    chk("ovf_err_count", err_count, 3);

    setup(16'h1000, 16'h1000, 16'h0100, 16'h0200, 4'd1, 1, 1);
    run_step(3, 0);
    chk("busy_start_ild_n", ild_n, 1);
    chk("busy_start_done_n", done_n, 1);
    chk("busy_start_done_cyc", done_cyc, 6);
    chk("busy_start_idle", busy, 0);

    setup(16'h1000, 16'hF000, 16'h0800, 16'h0000, 4'd1, 1, 0);
    @(negedge clk) start = 1;
    @(posedge clk); #1 start = 0;
    @(posedge clk); #3 rst_n = 0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_in1_out", in1_out, 0);
    chk("abort_err_count", err_count, 0);
    chk("abort_w1", weight1_new, 0);
    chk("abort_error", error, 0);
    @(negedge clk) rst_n = 1;
    wl = 0; dn = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (weight_ld) wl++;
      if (done) dn++;
    end
    chk("abort_no_wld", wl, 0);
    chk("abort_no_done", dn, 0);
    setup(16'h1000, 16'hF000, 16'h0800, 16'h0000, 4'd1, 1, 0);
    run_step(0, 0);
    chk("after_abort_wld_cyc", wld_cyc, 5);
    chk("after_abort_done_cyc", done_cyc, 6);
    chk("after_abort_w1", weight1_new, 16'h1000);
    chk("after_abort_err_count", err_count, 1);

    @(negedge clk) force dut.ec_q = 16'hFFFF;
    @(posedge clk); #1 release dut.ec_q;
    @(posedge clk); #1 chk("preset_err_count", err_count, 16'hFFFF);
    setup(16'h1000, 16'hF000, 16'h0800, 16'h0000, 4'd1, 1, 0);
    run_step(0, 0);
    chk("sat_err_count", err_count, 16'hFFFF);
    setup(16'h1000, 16'hF000, 16'h0800, 16'h0000, 4'd1, 1, 0);
    run_step(0, 4);
    chk("clear_wins", err_count, 16'h0000);
    setup(16'h1000, 16'hF000, 16'h0800, 16'h0000, 4'd1, 1, 0);
    run_step(0, 0);
    chk("count_after_clear", err_count, 16'h0001);
    @(negedge clk) clear = 1;
    @(negedge clk) clear = 0;
    chk("clear_idle", err_count, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/perceptron_trainer.md
PERCEPTRON_TRAINER -- requirements
Module: perceptron_trainer

Interface
REQ-001 SHALL have parameter fp_integer_width, default 4, integer bits of signed two's-complement fixed-point values.
REQ-002 SHALL have parameter fp_fract_width, default 12, fraction bits; fp_width = fp_integer_width + fp_fract_width, at most 16.
REQ-003 SHALL have parameter settle_cycles, default 2, range 1-15, cycles allowed for the perceptron result to settle after an input load.
REQ-004 SHALL have ports:
- clk  input  1  single clock; all logic on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request one training step; sampled only in IDLE.
- in1, in2  input  fp_width  training sample.
- target  input  1  expected classification.
- rate  input  4  learning-rate shift; eta = 2^-rate.
- weight1, weight2  input  fp_width  current perceptron weights.
- result  input  1  perceptron output.
- clear  input  1  clears err_count.
- in1_out, in2_out  output  fp_width  sample presented to the perceptron input registers.
- input_ld  output  1  one-cycle load strobe for the perceptron inputs.
- weight1_new, weight2_new  output  fp_width  updated weights.
- weight_ld  output  1  one-cycle weight write strobe, shared by both weights.
- busy  output  1  high whenever the state is not IDLE.
- done  output  1  one-cycle completion pulse.
- error  output  1  misclassification flag of the last step; held until the next step's EVAL.
- err_count  output  16  saturating misclassification counter.

Function
REQ-005 SHALL implement states IDLE, LOAD, SETTLE, EVAL, WRITE, DONE.
REQ-006 IDLE: start=1 SHALL latch in1, in2, target and rate and go to LOAD; start=0 SHALL stay in IDLE.
REQ-007 LOAD SHALL assert input_ld for exactly one cycle, drive in1_out/in2_out with the latched sample, and go to SETTLE.
REQ-008 SETTLE SHALL last exactly settle_cycles cycles, counted by an internal counter, then go to EVAL.
REQ-009 EVAL SHALL sample result and set error = (result != target).
REQ-010 If error=1, EVAL SHALL compute weightN_new = weightN + s * (inN >>> rate), with s = +1 when target=1 and s = -1 when target=0, using an arithmetic shift.
REQ-011 If error=0, EVAL SHALL set weightN_new = weightN.
REQ-012 WRITE SHALL assert weight_ld for one cycle only when error=1, then go to DONE.
REQ-013 DONE SHALL pulse done for one cycle and return to IDLE.
REQ-014 Latency SHALL be fixed: with start accepted at cycle 0, input_ld is at cycle 1, EVAL at cycle 2+settle_cycles, weight_ld at 3+settle_cycles and done at 4+settle_cycles, regardless of error.
REQ-015 start while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-016 err_count SHALL increment in EVAL when error=1 and hold at 0xFFFF without wrapping.
REQ-017 clear SHALL zero err_count in any state; when clear and an increment coincide, clear SHALL win.
REQ-018 Latched sample, rate and target SHALL NOT change between LOAD and DONE, even if the inputs change.
REQ-019 weight1_new/weight2_new SHALL hold their value between steps.

Reset
REQ-020 rst_n low SHALL force IDLE immediately, including mid-step.
REQ-021 rst_n low SHALL zero in1_out, in2_out, weight1_new, weight2_new, err_count and the settle counter.
REQ-022 rst_n low SHALL drive input_ld, weight_ld, busy, done and error to 0.
REQ-023 A step aborted by reset SHALL produce no weight_ld and no done.

Configuration
REQ-024 Macro TRAINER_SATURATE_EN defined: the weight update SHALL saturate to the most positive (0x7FFF for 16 bits) or most negative (0x8000) fp_width value on overflow.
REQ-025 Macro TRAINER_SATURATE_EN undefined: the weight update SHALL wrap modulo 2^fp_width.

Verification
REQ-026 Correction: weight1=0x0800, weight2=0x0000, in1=0x1000, in2=0xF000, rate=1, target=1, result=0 -> weight1_new=0x1000, weight2_new=0xF800, weight_ld at cycle 5 (settle_cycles=2), done at cycle 6, err_count=1.
REQ-027 Correct classification: target=result=1 -> no weight_ld, done at cycle 6, error=0, err_count unchanged.
REQ-028 Overflow: weight1=0x7F00, in1=0x1000, rate=0, target=1, result=0 -> weight1_new=0x7FFF with TRAINER_SATURATE_EN defined, 0x8F00 without it.
REQ-029 start pulsed during SETTLE -> ignored; exactly one input_ld and one done occur.
REQ-030 rst_n asserted in SETTLE -> busy=0 immediately, no weight_ld, no done, and a following start runs a normal step.
REQ-031 err_count preset to 0xFFFF plus another error -> stays 0xFFFF; clear coinciding with an error increment -> 0x0000.
